// File: rtl/m_dm_pkg.sv
// Shared definitions for the M-stage data-memory port:
// access-size codes, exception codes and the port FSM states.
package m_dm_pkg;

  localparam logic [1:0] DM_WORD = 2'b00;
  localparam logic [1:0] DM_HALF = 2'b01;
  localparam logic [1:0] DM_BYTE = 2'b10;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_ADEL  = 2'b01;
  localparam logic [1:0] EXC_ADES  = 2'b10;
  localparam logic [1:0] EXC_BUSTO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } dm_state_e;

endpackage

// File: rtl/m_dm_port_if.sv
// Request/acknowledge data-memory bus between the M-stage port
// (master) and the external memory (slave).
interface m_dm_port_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_byteen, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_byteen, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/m_dm_align.sv
// Combinational lane logic: misalignment check, store byte enables
// and lane replication, load lane extraction with sign/zero extend.
module m_dm_align
  import m_dm_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  op_i,
  input  logic        sign_i,
  input  logic        store_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] rdata_i,
  output logic        misal_o,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lb;
  logic [15:0] lh;

  assign lb = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign lh = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    misal_o  = 1'b0;
    byteen_o = 4'b1111;
    wdata_o  = rt_i;
    ldata_o  = rdata_i;
    unique case (1'b1)
      (op_i == DM_BYTE): begin
        if (store_i) begin
          byteen_o = 4'b0001 << addr_lo_i;
          wdata_o  = {4{rt_i[7:0]}};
        end
        ldata_o = {{24{sign_i & lb[7]}}, lb};
      end
      (op_i == DM_HALF): begin
        misal_o = addr_lo_i[0];
        if (store_i) begin
          byteen_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o  = {2{rt_i[15:0]}};
        end
        ldata_o = {{16{sign_i & lh[15]}}, lh};
      end
      default: misal_o = |addr_lo_i;
    endcase
  end

endmodule

// File: rtl/m_dm_port.sv
// M-stage data-memory port: req/ack bus transaction with pipeline stall.
// Optional bus-ack timeout when M_DM_TIMEOUT_EN is defined.
module m_dm_port
  import m_dm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_ALU_out,
  input  logic [31:0] M_ReadData_rt,
  input  logic [1:0]  M_CU_DM_op,
  input  logic        M_CU_DM_sign,
  input  logic        M_CU_EN_DMWrite,
  input  logic        M_CU_EN_DMRead,
  input  logic        M_hold,
  m_dm_port_if.master bus,
  output logic        M_DM_stall,
  output logic [31:0] M_DM_rdata,
  output logic [1:0]  M_DM_exc
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_to_range
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  dm_state_e   state_q, state_d;
  logic        access, store, misal, pending, to_hit;
  logic [3:0]  be;
  logic [31:0] wd, ld;
  logic        req_q, we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  // a load+store combination is issued as a store
  assign access  = M_CU_EN_DMRead | M_CU_EN_DMWrite;
  assign store   = M_CU_EN_DMWrite;
  assign pending = access & ~misal;

  m_dm_align u_align (
    .addr_lo_i (M_ALU_out[1:0]),
    .op_i      (M_CU_DM_op),
    .sign_i    (M_CU_DM_sign),
    .store_i   (store),
    .rt_i      (M_ReadData_rt),
    .rdata_i   (bus.bus_rdata),
    .misal_o   (misal),
    .byteen_o  (be),
    .wdata_o   (wd),
    .ldata_o   (ld)
  );

`ifdef M_DM_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       to_q;

  assign to_hit = (state_q == S_REQ) & ~bus.bus_ack &
                  (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && pending)
        cnt_q <= '0;
      else if (state_q == S_REQ && !bus.bus_ack)
        cnt_q <= cnt_q + 8'd1;
      if (to_hit)
        to_q <= 1'b1;
      else if (state_q == S_DONE && !M_hold)
        to_q <= 1'b0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pending) state_d = S_REQ;
      S_REQ:  if (bus.bus_ack || to_hit) state_d = S_DONE;
      S_DONE: if (!M_hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    M_DM_stall = 1'b0;
    M_DM_exc   = EXC_NONE;
    unique case (state_q)
      S_IDLE: begin
        M_DM_stall = pending;
        if (access && misal)
          M_DM_exc = store ? EXC_ADES : EXC_ADEL;
      end
      S_REQ: M_DM_stall = 1'b1;
      S_DONE: begin
`ifdef M_DM_TIMEOUT_EN
        if (to_q) M_DM_exc = EXC_BUSTO;
`endif
      end
      default: M_DM_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && pending) begin
        req_q   <= 1'b1;
        we_q    <= store;
        addr_q  <= {M_ALU_out[31:2], 2'b00};
        be_q    <= be;
        wdata_q <= wd;
      end else if (state_q == S_REQ && (bus.bus_ack || to_hit)) begin
        req_q <= 1'b0;
      end
      if (state_q == S_REQ && bus.bus_ack)
        rdata_q <= ld;
    end
  end

  assign bus.bus_req    = req_q;
  assign bus.bus_we     = we_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_byteen = be_q;
  assign bus.bus_wdata  = wdata_q;
  assign M_DM_rdata     = rdata_q;

endmodule
